// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, default widths
// and the bundle of per-cycle pipeline control strobes.
package pipe_ctrl_pkg;

    localparam int XLEN_DEF = 32;
    localparam int RIDX_DEF = 5;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        IKILL = 2'd2
    } ctrl_state_t;

    typedef struct packed {
        logic pc_hold;
        logic pc_redirect;
        logic ifid_hold;
        logic ifid_flush;
        logic idex_stall;
        logic idex_flush;
        logic mem_stall;
    } ctrl_t;

    function automatic ctrl_t ctrl_idle();
        ctrl_t c;
        c = '0;
        return c;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Load-use comparator: flags an ID instruction that reads the register an
// in-flight load in ID/EX is about to write (x0 never creates a hazard).
module load_use_detect #(
    parameter int RIDX = 5
) (
    input  logic [RIDX-1:0] id_rs1,
    input  logic [RIDX-1:0] id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [RIDX-1:0] ex_rd,
    input  logic            ex_mem_ren,
    output logic            load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = id_use_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit  = id_use_rs2 && (id_rs2 == ex_rd);
    assign load_use = ex_mem_ren && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hold/flush/redirect controller for the 5-stage core.
// Optional perf counters are built when PIPE_CTRL_PERF_EN is defined.
//
// state | meaning
// BOOT  | first cycle after reset, pipeline held and flushed
// RUN   | normal issue, hazards decoded combinationally
// IKILL | mispredict seen during I-cache miss, waiting to replay target_r
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int RIDX = RIDX_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [RIDX-1:0] id_rs1,
    input  logic [RIDX-1:0] id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [RIDX-1:0] ex_rd,
    input  logic            ex_mem_ren,
    input  logic            ex_mispredict,
    input  logic [XLEN-1:0] ex_target,
    input  logic            icache_stall,
    input  logic            dcache_stall,
    output logic            pc_hold,
    output logic            pc_redirect,
    output logic [XLEN-1:0] pc_redirect_addr,
    output logic            ifid_hold,
    output logic            ifid_flush,
    output logic            idex_stall,
    output logic            idex_flush,
    output logic            mem_stall,
`ifdef PIPE_CTRL_PERF_EN
    output logic [31:0]     perf_luse_cnt,
    output logic [31:0]     perf_dstall_cnt,
    output logic [31:0]     perf_redirect_cnt,
`endif
    output logic [1:0]      state_o
);

    ctrl_state_t     state;
    ctrl_state_t     state_nxt;
    logic [XLEN-1:0] target_r;
    logic [XLEN-1:0] target_nxt;
    ctrl_t           ctrl;
    logic            load_use;
    logic            luse_active;
    logic            dstall_active;

    load_use_detect #(.RIDX(RIDX)) u_load_use_detect (
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .ex_rd      (ex_rd),
        .ex_mem_ren (ex_mem_ren),
        .load_use   (load_use)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= BOOT;
            target_r <= '0;
        end else begin
            state    <= state_nxt;
            target_r <= target_nxt;
        end
    end

    always_comb begin
        ctrl          = ctrl_idle();
        state_nxt     = state;
        target_nxt    = target_r;
        luse_active   = 1'b0;
        dstall_active = 1'b0;
        case (state)
            RUN: begin
                if (dcache_stall) begin
                    // Freeze everything; a pending mispredict stays visible from frozen EX.
                    ctrl.pc_hold    = 1'b1;
                    ctrl.ifid_hold  = 1'b1;
                    ctrl.idex_stall = 1'b1;
                    ctrl.mem_stall  = 1'b1;
                    dstall_active   = 1'b1;
                end else if (ex_mispredict && !icache_stall) begin
                    ctrl.pc_redirect = 1'b1;
                    ctrl.ifid_flush  = 1'b1;
                    ctrl.idex_flush  = 1'b1;
                end else if (ex_mispredict) begin
                    target_nxt      = ex_target;
                    ctrl.pc_hold    = 1'b1;
                    ctrl.ifid_flush = 1'b1;
                    ctrl.idex_flush = 1'b1;
                    state_nxt       = IKILL;
                end else if (load_use) begin
                    ctrl.pc_hold    = 1'b1;
                    ctrl.ifid_hold  = 1'b1;
                    ctrl.idex_flush = 1'b1;
                    luse_active     = 1'b1;
                end else if (icache_stall) begin
                    ctrl.pc_hold    = 1'b1;
                    ctrl.ifid_flush = 1'b1;
                end
            end
            IKILL: begin
                if (dcache_stall) begin
                    ctrl.pc_hold    = 1'b1;
                    ctrl.ifid_hold  = 1'b1;
                    ctrl.idex_stall = 1'b1;
                    ctrl.mem_stall  = 1'b1;
                    dstall_active   = 1'b1;
                end else if (icache_stall) begin
                    ctrl.pc_hold    = 1'b1;
                    ctrl.ifid_flush = 1'b1;
                    ctrl.idex_flush = 1'b1;
                end else begin
                    ctrl.pc_redirect = 1'b1;
                    ctrl.ifid_flush  = 1'b1;
                    ctrl.idex_flush  = 1'b1;
                    state_nxt        = RUN;
                end
            end
            default: begin
                ctrl.pc_hold    = 1'b1;
                ctrl.ifid_flush = 1'b1;
                ctrl.idex_flush = 1'b1;
                state_nxt       = RUN;
            end
        endcase
    end

    assign pc_hold          = ctrl.pc_hold;
    assign pc_redirect      = ctrl.pc_redirect;
    assign ifid_hold        = ctrl.ifid_hold;
    assign ifid_flush       = ctrl.ifid_flush;
    assign idex_stall       = ctrl.idex_stall;
    assign idex_flush       = ctrl.idex_flush;
    assign mem_stall        = ctrl.mem_stall;
    assign pc_redirect_addr = (state == IKILL) ? target_r : ex_target;
    assign state_o          = state;

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_luse_cnt     <= '0;
            perf_dstall_cnt   <= '0;
            perf_redirect_cnt <= '0;
        end else begin
            if (luse_active)      perf_luse_cnt     <= perf_luse_cnt + 32'd1;
            if (dstall_active)    perf_dstall_cnt   <= perf_dstall_cnt + 32'd1;
            if (ctrl.pc_redirect) perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
        end
    end
`else
    logic perf_unused;
    assign perf_unused = luse_active ^ dstall_active;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl; control outputs are
// compared as a 7-bit vector {pc_hold,redirect,ifid_hold,ifid_flush,idex_stall,idex_flush,mem_stall}.
module tb_pipe_hazard_ctrl;

    localparam logic [6:0] C_IDLE   = 7'b0000000;
    localparam logic [6:0] C_BOOT   = 7'b1001010;
    localparam logic [6:0] C_KILL   = 7'b1001010;
    localparam logic [6:0] C_LUSE   = 7'b1010010;
    localparam logic [6:0] C_REDIR  = 7'b0101010;
    localparam logic [6:0] C_FREEZE = 7'b1010101;
    localparam logic [6:0] C_ISTALL = 7'b1001000;
    localparam logic [1:0] S_BOOT = 2'd0, S_RUN = 2'd1, S_IKILL = 2'd2;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_use_rs1, id_use_rs2, ex_mem_ren, ex_mispredict;
    logic [31:0] ex_target;
    logic        icache_stall, dcache_stall;
    logic        pc_hold, pc_redirect, ifid_hold, ifid_flush;
    logic        idex_stall, idex_flush, mem_stall;
    logic [31:0] pc_redirect_addr;
    logic [1:0]  state_o;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_luse_cnt, perf_dstall_cnt, perf_redirect_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .id_rs1           (id_rs1),
        .id_rs2           (id_rs2),
        .id_use_rs1       (id_use_rs1),
        .id_use_rs2       (id_use_rs2),
        .ex_rd            (ex_rd),
        .ex_mem_ren       (ex_mem_ren),
        .ex_mispredict    (ex_mispredict),
        .ex_target        (ex_target),
        .icache_stall     (icache_stall),
        .dcache_stall     (dcache_stall),
        .pc_hold          (pc_hold),
        .pc_redirect      (pc_redirect),
        .pc_redirect_addr (pc_redirect_addr),
        .ifid_hold        (ifid_hold),
        .ifid_flush       (ifid_flush),
        .idex_stall       (idex_stall),
        .idex_flush       (idex_flush),
        .mem_stall        (mem_stall),
`ifdef PIPE_CTRL_PERF_EN
        .perf_luse_cnt     (perf_luse_cnt),
        .perf_dstall_cnt   (perf_dstall_cnt),
        .perf_redirect_cnt (perf_redirect_cnt),
`endif
        .state_o          (state_o)
    );

    wire [6:0] ctrl_vec = {pc_hold, pc_redirect, ifid_hold, ifid_flush,
                           idex_stall, idex_flush, mem_stall};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_rd = '0; ex_mem_ren = 0; ex_mispredict = 0; ex_target = '0;
        icache_stall = 0; dcache_stall = 0;
    endtask

    task automatic expect_cs(input string tag, input logic [6:0] c, input logic [1:0] s);
        #1;
        chk({tag, "_ctrl"}, {25'd0, ctrl_vec}, {25'd0, c});
        chk({tag, "_state"}, {30'd0, state_o}, {30'd0, s});
    endtask

    initial begin
        idle_in();
        rst = 1'b1;
        cyc();
        expect_cs("in_reset", C_BOOT, S_BOOT);
        cyc();
        rst = 1'b0;
        expect_cs("boot", C_BOOT, S_BOOT);
        cyc();
        expect_cs("run_idle", C_IDLE, S_RUN);

        // Load-use via rs2: one bubble, then the load has moved on.
        ex_mem_ren = 1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1;
        expect_cs("luse_rs2", C_LUSE, S_RUN);
        cyc(); idle_in();
        expect_cs("luse_done", C_IDLE, S_RUN);
        ex_mem_ren = 1; ex_rd = 5'd0; id_rs2 = 5'd0; id_use_rs2 = 1;
        expect_cs("luse_x0", C_IDLE, S_RUN);
        ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1; id_rs2 = 5'd3;
        expect_cs("luse_rs1", C_LUSE, S_RUN);
        id_use_rs1 = 0;
        expect_cs("luse_unused_rs1", C_IDLE, S_RUN);
        id_use_rs1 = 1; ex_mem_ren = 0;
        expect_cs("no_load", C_IDLE, S_RUN);
        ex_mem_ren = 1; icache_stall = 1;
        expect_cs("luse_over_istall", C_LUSE, S_RUN);
        cyc(); idle_in(); icache_stall = 1;
        expect_cs("istall", C_ISTALL, S_RUN);

        // Mispredict with fetch idle: same-cycle redirect.
        cyc(); idle_in();
        ex_mispredict = 1; ex_target = 32'h0000_0100;
        expect_cs("redir", C_REDIR, S_RUN);
        chk("redir_addr", pc_redirect_addr, 32'h0000_0100);
        cyc(); idle_in();
        expect_cs("redir_after", C_IDLE, S_RUN);

        // Mispredict during I-cache miss: buffered and replayed.
        ex_mispredict = 1; ex_target = 32'h0000_0200; icache_stall = 1;
        expect_cs("ikill_enter", C_KILL, S_RUN);
        for (int i = 0; i < 3; i++) begin
            cyc(); idle_in(); icache_stall = 1; ex_target = 32'hDEAD_BEEF;
            expect_cs($sformatf("ikill_wait%0d", i), C_KILL, S_IKILL);
            chk($sformatf("ikill_addr%0d", i), pc_redirect_addr, 32'h0000_0200);
        end
        cyc(); icache_stall = 0;
        expect_cs("ikill_replay", C_REDIR, S_IKILL);
        chk("ikill_replay_addr", pc_redirect_addr, 32'h0000_0200);
        cyc(); idle_in();
        expect_cs("ikill_back", C_IDLE, S_RUN);

        // D-cache freeze holds a pending mispredict for four cycles.
        ex_mispredict = 1; ex_target = 32'h0000_0300; dcache_stall = 1;
        for (int i = 0; i < 4; i++) begin
            expect_cs($sformatf("dfreeze%0d", i), C_FREEZE, S_RUN);
            cyc();
        end
        dcache_stall = 0;
        expect_cs("dfreeze_redir", C_REDIR, S_RUN);
        chk("dfreeze_addr", pc_redirect_addr, 32'h0000_0300);

        // D-cache freeze inside IKILL keeps state and buffered target.
        cyc(); idle_in();
        ex_mispredict = 1; ex_target = 32'h0000_0440; icache_stall = 1;
        cyc(); idle_in(); dcache_stall = 1; icache_stall = 1;
        expect_cs("ikill_dfreeze", C_FREEZE, S_IKILL);
        cyc(); idle_in();
        expect_cs("ikill_dfreeze_out", C_REDIR, S_IKILL);
        chk("ikill_dfreeze_addr", pc_redirect_addr, 32'h0000_0440);

        // Async reset mid-IKILL discards the buffered target.
        cyc(); idle_in();
        ex_mispredict = 1; ex_target = 32'h0000_0500; icache_stall = 1;
        cyc(); idle_in(); icache_stall = 1;
        expect_cs("pre_rst_ikill", C_KILL, S_IKILL);
        rst = 1'b1;
        expect_cs("async_rst", C_BOOT, S_BOOT);
        chk("async_rst_addr", pc_redirect_addr, 32'h0);
        cyc(); idle_in(); rst = 1'b0;
        expect_cs("rst_boot", C_BOOT, S_BOOT);
        cyc();
        expect_cs("rst_run", C_IDLE, S_RUN);

`ifdef PIPE_CTRL_PERF_EN
        rst = 1'b1;
        #1;
        chk("perf_rst_luse", perf_luse_cnt, 32'd0);
        cyc(); rst = 1'b0;
        cyc();
        ex_mem_ren = 1; ex_rd = 5'd9; id_rs1 = 5'd9; id_use_rs1 = 1;
        cyc(); cyc(); idle_in();
        dcache_stall = 1;
        cyc(); cyc(); cyc(); cyc(); idle_in();
        ex_mispredict = 1; ex_target = 32'h0000_0600;
        cyc(); idle_in();
        #1;
        chk("perf_luse", perf_luse_cnt, 32'd2);
        chk("perf_dstall", perf_dstall_cnt, 32'd4);
        chk("perf_redirect", perf_redirect_cnt, 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
